rob_reader: RTL and testbench

ROB_READER -- requirements
Module: rob_reader

---
 rtl/rob_reader.sv | 98 +++++++++
 tb/tb_rob_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rob_reader.sv
// In-order retire reader for a reorder buffer: tracks completed slots in a bitmap and streams them out through a registered-read RAM.
// Optional flush input is built only when ROB_RD_FLUSH_EN is defined.
module rob_reader #(
    parameter int depth  = 8,
    parameter int awidth = 3,
    parameter int width  = 34
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp_valid,
    input  logic [awidth-1:0] cmp_addr,
    output logic              mem_rden,
    output logic [awidth-1:0] mem_raddress,
    input  logic [width-1:0]  mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [width-1:0]  out_data,
`ifdef ROB_RD_FLUSH_EN
    input  logic              flush,
`endif
    output logic [awidth-1:0] head_ptr
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t            state_q, state_d;
    logic [depth-1:0]  done_q, done_d;
    logic [awidth-1:0] head_q, head_d;
    logic [awidth-1:0] head_next;
    logic              handshake;
    logic              clr;

`ifdef ROB_RD_FLUSH_EN
    assign clr = !rst_n || flush;
`else
    assign clr = !rst_n;
`endif

    assign head_next = head_q + awidth'(1);
    assign handshake = (state_q == PRESENT) && out_ready;
    assign head_ptr  = clr ? '0 : head_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            head_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        done_d  = done_q;
        case (state_q)
            IDLE:    if (done_q[head_q]) state_d = FETCH;
            FETCH:   state_d = PRESENT;
            PRESENT: begin
                if (out_ready) begin
                    head_d         = head_next;
                    done_d[head_q] = 1'b0;
                    // Next slot must already be marked done to chain without a gap.
                    state_d = done_q[head_next] ? PRESENT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A completion landing on the slot being retired wins over the clear.
        if (cmp_valid) done_d[cmp_addr] = 1'b1;
    end

    always_comb begin
        mem_rden     = 1'b0;
        mem_raddress = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        if (!clr) begin
            mem_raddress = head_q;
            case (state_q)
                IDLE:    mem_rden = done_q[head_q];
                PRESENT: begin
                    out_valid = 1'b1;
                    out_data  = mem_rdata;
                    if (handshake) begin
                        mem_rden     = done_q[head_next];
                        mem_raddress = head_next;
                    end
                end
                default: mem_rden = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_reader.sv
// Randomized bench for rob_reader with a slot-level reference model and a registered-read RAM.
// Define ROB_RD_FLUSH_EN to also exercise the flush input.
module tb_rob_reader;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int W     = 34;

    logic          clk = 1'b0;
    logic          rst_n, cmp_valid, out_ready;
    logic [AW-1:0] cmp_addr, mem_raddress, head_ptr;
    logic          mem_rden, out_valid;
    logic [W-1:0]  mem_rdata, out_data;
`ifdef ROB_RD_FLUSH_EN
    logic          flush;
`endif

    rob_reader #(.depth(DEPTH), .awidth(AW), .width(W)) dut (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
        .mem_rden(mem_rden), .mem_raddress(mem_raddress), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef ROB_RD_FLUSH_EN
        .flush(flush),
`endif
        .head_ptr(head_ptr)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) if (mem_rden) mem_rdata <= mem[mem_raddress];

    // Reference state: which slots are completed-but-unretired, and the oldest slot.
    logic [DEPTH-1:0] md;
    logic [AW-1:0]    mhead;
    int               wait_cnt, retired, rden_cnt, checks, failures;
    logic             prev_rden, prev_valid, prev_stall;
    logic [W-1:0]     prev_data;
    int               hs_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic cv, input logic [AW-1:0] ca, input logic rdy,
                        input logic rst, input logic fl);
        logic [AW-1:0] nh;
        logic          exp_rden;
        @(negedge clk);
        cmp_valid = cv; cmp_addr = ca; out_ready = rdy; rst_n = !rst;
`ifdef ROB_RD_FLUSH_EN
        flush = fl;
`else
        if (fl) rst_n = 1'b0;
`endif
        #1;
        nh = mhead + AW'(1);
        if (rst || fl) begin
            check("clr_valid", out_valid, 0);
            check("clr_rden", mem_rden, 0);
            check("clr_raddr", mem_raddress, 0);
            check("clr_head", head_ptr, 0);
            md = '0; mhead = '0; wait_cnt = 0;
        end else begin
            check("head", head_ptr, mhead);
            exp_rden = out_valid ? (rdy && md[nh]) : (md[mhead] && !prev_rden);
            check("rden", mem_rden, exp_rden);
            if (mem_rden) check("raddr", mem_raddress, out_valid ? nh : mhead);
            if (out_valid) begin
                check("valid_done", md[mhead], 1);
                check("data", out_data, mem[mhead]);
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && !prev_valid) check("latency", wait_cnt, 2);
            wait_cnt = (md[mhead] && !out_valid) ? wait_cnt + 1 : 0;
            check("wait_bound", wait_cnt > 2, 0);
            if (out_valid && rdy) begin
                hs_log.push_back(int'(head_ptr));
                retired++;
                md[mhead] = 1'b0;
                mhead = nh;
            end
            if (cv) begin
                md[ca] = 1'b1;
                mem[ca] = W'({$urandom, $urandom});
            end
        end
        if (mem_rden) rden_cnt++;
        prev_rden  = mem_rden;
        prev_valid = out_valid;
        prev_stall = out_valid && !rdy;
        prev_data  = out_data;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, '0, rdy, 0, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) step(0, '0, 0, 1, 0);
    endtask

    int r0, c0;
    logic [AW-1:0] ra;
    logic          rv;

    initial begin
        checks = 0; failures = 0; retired = 0; rden_cnt = 0; wait_cnt = 0;
        md = '0; mhead = '0;
        prev_rden = 0; prev_valid = 0; prev_stall = 0; prev_data = '0;
        cmp_valid = 0; cmp_addr = '0; out_ready = 0; rst_n = 0;
`ifdef ROB_RD_FLUSH_EN
        flush = 0;
`endif
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Burst of three completions retires back to back.
        do_reset();
        r0 = retired; c0 = rden_cnt;
        for (int s = 0; s < 3; s++) step(1, AW'(s), 1, 0, 0);
        idle(5, 1);
        check("burst_head", head_ptr, 3);
        check("burst_rden", rden_cnt - c0, 3);
        check("burst_retired", retired - r0, 3);

        // Out-of-order completion waits for the head slot.
        do_reset();
        r0 = retired;
        step(1, 1, 1, 0, 0);
        idle(5, 1);
        check("ooo_wait", retired - r0, 0);
        step(1, 0, 1, 0, 0);
        idle(6, 1);
        check("ooo_retired", retired - r0, 2);
        check("ooo_head", head_ptr, 2);

        // Backpressure holds the presented entry.
        do_reset();
        r0 = retired;
        step(1, 0, 0, 0, 0);
        idle(8, 0);
        check("stall_valid", out_valid, 1);
        idle(3, 1);
        check("stall_retired", retired - r0, 1);

        // Reset while presenting discards the entry and a concurrent completion.
        do_reset();
        r0 = retired;
        step(1, 0, 0, 0, 0);
        idle(4, 0);
        step(1, 1, 0, 1, 0);
        step(0, '0, 1, 0, 0);
        check("rst_valid", out_valid, 0);
        idle(6, 1);
        check("rst_lost", retired - r0, 0);
        check("rst_head", head_ptr, 0);

        // Completion on the slot being retired keeps it done for the next lap.
        do_reset();
        r0 = retired;
        step(1, 0, 0, 0, 0);
        idle(3, 0);
        step(1, 0, 1, 0, 0);
        for (int s = 1; s < DEPTH; s++) step(1, AW'(s), 1, 0, 0);
        idle(12, 1);
        check("setwin_retired", retired - r0, 9);
        check("setwin_head", head_ptr, 1);

        // Ten retirements wrap the head pointer.
        do_reset();
        hs_log.delete();
        for (int i = 0; i < 10; i++) step(1, AW'(i % DEPTH), 1, 0, 0);
        idle(8, 1);
        check("wrap_count", hs_log.size(), 10);
        for (int i = 0; i < 10 && i < hs_log.size(); i++)
            check("wrap_seq", hs_log[i], i % DEPTH);

`ifdef ROB_RD_FLUSH_EN
        do_reset();
        r0 = retired;
        for (int s = 3; s < 6; s++) step(1, AW'(s), 1, 0, 0);
        step(0, '0, 1, 0, 1);
        for (int s = 0; s < 3; s++) step(1, AW'(s), 1, 0, 0);
        idle(8, 1);
        check("flush_retired", retired - r0, 3);
        check("flush_head", head_ptr, 3);
`endif

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            rv = ($urandom_range(0, 1) == 1) && !md[ra];
            step(rv, ra, $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0, 0);
        end

        // Complete every idle slot, then drain.
        for (int s = 0; s < DEPTH; s++) step(!md[s], AW'(s), 1, 0, 0);
        idle(40, 1);
        check("drain_empty", md, 0);
        check("drain_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
